conv0_seq: RTL and testbench

Frame sequencer for the first convolution layer. It walks a 3x3 window over a binary input image held in the image bit buffer and fetches the nine taps of each window. It drives the layer's strt/din/tx_done interface once per output pixel, 26x26 = 676 pixels per frame. It sits between the image buffer and layer 0, and closes the frame once the downstream pooling stage acknowledges consumption.

---
 rtl/layer_pkg.sv | 39 +++
 rtl/conv0_seq_if.sv | 46 ++++
 rtl/conv0_win_addr.sv | 96 +++++++++
 rtl/conv0_seq.sv | 145 ++++++++++++++
 tb/tb_conv0_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/layer_pkg.sv
// -----------------------------------------------------------------------------
// layer_pkg
// Shared definitions for the layer-0 frame sequencer and its address walker.
//
// Contents:
//   IMG_W, K, OUT_W   image width, kernel width and output width in pixels
//   TAPS, PX_TOTAL    taps per window and output pixels per frame
//   ADDR_W, PX_W      image buffer address width and pixel counter width
//   OFF_ROW_STEP      offset jump when the kernel column wraps to the next row
//   BASE_ROW_STEP     extra base jump when the window column wraps
//   conv0_state_t     sequencer FSM states
// -----------------------------------------------------------------------------
package layer_pkg;

  localparam int IMG_W    = 28;
  localparam int K        = 3;
  localparam int OUT_W    = IMG_W - K + 1;
  localparam int TAPS     = K * K;
  localparam int PX_TOTAL = OUT_W * OUT_W;
  localparam int ADDR_W   = 10;
  localparam int PX_W     = 10;

  // Moving from tap (dr, K-1) to tap (dr+1, 0) skips the rest of the image row.
  localparam int OFF_ROW_STEP  = IMG_W - K + 1;

  // Moving from window (row, OUT_W-1) to (row+1, 0) jumps past the last K-1
  // pixels of the row plus the usual single-column step.
  localparam int BASE_ROW_STEP = K;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STRT,
    ST_FEED,
    ST_GAP,
    ST_WAIT_ACK,
    ST_DONE
  } conv0_state_t;

endpackage

// File: rtl/conv0_seq_if.sv
// -----------------------------------------------------------------------------
// conv0_seq_if
// Bundles the image-buffer read port and the layer-0 pixel interface that the
// frame sequencer drives.
//
// Signals:
//   img_addr      image buffer read address (data returns one cycle later)
//   img_bit       image pixel for the previous cycle's img_addr
//   conv_bsy      layer 0 busy, holds off the next pixel start
//   conv_strt     start one output pixel
//   conv_din      tap bit streamed to layer 0
//   conv_tx_done  one-cycle frame-end / flush pulse to layer 0
//
// Modports:
//   master  sequencer side
//   slave   image buffer + layer 0 side
// -----------------------------------------------------------------------------
interface conv0_seq_if;
  import layer_pkg::*;

  logic [ADDR_W-1:0] img_addr;
  logic              img_bit;
  logic              conv_bsy;
  logic              conv_strt;
  logic              conv_din;
  logic              conv_tx_done;

  modport master (
    output img_addr,
    input  img_bit,
    input  conv_bsy,
    output conv_strt,
    output conv_din,
    output conv_tx_done
  );

  modport slave (
    input  img_addr,
    output img_bit,
    output conv_bsy,
    input  conv_strt,
    input  conv_din,
    input  conv_tx_done
  );

endinterface

// File: rtl/conv0_win_addr.sv
// -----------------------------------------------------------------------------
// conv0_win_addr
// Walks the 3x3 window over the image and produces the tap read addresses
// without any multiplier: a per-window base and a per-tap offset are both
// advanced by small constant steps and summed for the output address.
//
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clr         return to window (0,0), tap 0
//   tap_inc     advance to the next tap of the current window
//   px_inc      advance to the next window (row-major)
//   img_addr    base + offset for the tap currently selected
//   last_tap    tap counter is one past the final tap (tap index TAPS)
//   last_px     current window is the bottom-right one
// -----------------------------------------------------------------------------
module conv0_win_addr
  import layer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              tap_inc,
  input  logic              px_inc,
  output logic [ADDR_W-1:0] img_addr,
  output logic              last_tap,
  output logic              last_px
);

  localparam logic [4:0]        POS_LAST  = 5'(OUT_W - 1);
  localparam logic [1:0]        DC_LAST   = 2'(K - 1);
  localparam logic [3:0]        TAP_END   = 4'(TAPS);
  localparam logic [ADDR_W-1:0] OFF_STEP  = ADDR_W'(OFF_ROW_STEP);
  localparam logic [ADDR_W-1:0] BASE_STEP = ADDR_W'(BASE_ROW_STEP);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [4:0]        row;
  logic [4:0]        col;
  logic [3:0]        tap;
  logic [1:0]        dc;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] offset;

  // Tap walker: the counter runs 0..TAPS so that the sequencer can present
  // tap t+1 while tap t's data is returning; the extra step at TAPS is the
  // final FEED cycle and simply rewinds the offset for the next window.
  // Window walker: base tracks row*IMG_W + col, stepping one column at a time
  // and jumping to the next image row when the column wraps.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row    <= '0;
      col    <= '0;
      tap    <= '0;
      dc     <= '0;
      base   <= '0;
      offset <= '0;
    end else begin
      if (tap_inc) begin
        if (last_tap) begin
          tap    <= '0;
          dc     <= '0;
          offset <= '0;
        end else begin
          tap <= tap + 4'd1;
          if (dc == DC_LAST) begin
            dc     <= '0;
            offset <= offset + OFF_STEP;
          end else begin
            dc     <= dc + 2'd1;
            offset <= offset + ONE;
          end
        end
      end
      if (px_inc) begin
        if (col == POS_LAST) begin
          col <= '0;
          if (row == POS_LAST) begin
            row  <= '0;
            base <= '0;
          end else begin
            row  <= row + 5'd1;
            base <= base + BASE_STEP;
          end
        end else begin
          col  <= col + 5'd1;
          base <= base + ONE;
        end
      end
    end
  end

  // The largest real tap address is 783, so the sum never wraps in 10 bits.
  assign img_addr = base + offset;
  assign last_tap = (tap == TAP_END);
  assign last_px  = (row == POS_LAST) && (col == POS_LAST);

endmodule

// File: rtl/conv0_seq.sv
// -----------------------------------------------------------------------------
// conv0_seq
// Frame sequencer for convolution layer 0. For each of the 26x26 output
// pixels it issues conv_strt, streams the nine window taps from the image
// buffer into layer 0, then leaves one gap cycle for the layer's write. After
// the last pixel it waits for the pooling stage to acknowledge the frame and
// closes it with a conv_tx_done / frm_done pulse. abort closes a frame early.
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   frm_start    pulse: image buffer holds a complete frame (IDLE only)
//   frm_ack      pulse: downstream consumed the frame (WAIT_ACK only)
//   abort        pulse: drop the current frame (any active state)
//   bus          image buffer read port and layer-0 interface (master side)
//   frm_busy     high from frame accept until the closing DONE cycle
//   frm_done     one-cycle pulse in the closing DONE cycle
//   px_cnt       output pixels issued in the current frame
// -----------------------------------------------------------------------------
module conv0_seq
  import layer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frm_start,
  input  logic              frm_ack,
  input  logic              abort,
  conv0_seq_if.master       bus,
  output logic              frm_busy,
  output logic              frm_done,
  output logic [PX_W-1:0]   px_cnt
);

  conv0_state_t state;
  conv0_state_t state_nxt;

  logic clr;
  logic tap_inc;
  logic px_inc;
  logic last_tap;
  logic last_px;
  logic strt_c;
  logic tx_done_c;
  logic px_clr;

  conv0_win_addr u_win_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .tap_inc  (tap_inc),
    .px_inc   (px_inc),
    .img_addr (bus.img_addr),
    .last_tap (last_tap),
    .last_px  (last_px)
  );

  // State register. Layer 0 shares this reset, so a reset simply drops back
  // to IDLE without any flush pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle controls. abort takes priority everywhere except
  // IDLE (nothing to drop) and DONE (already closing). While aborting, the
  // address walker and pixel counter are frozen so nothing half-advances.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    tap_inc   = 1'b0;
    px_inc    = 1'b0;
    strt_c    = 1'b0;
    tx_done_c = 1'b0;
    px_clr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        clr = 1'b1;
        if (frm_start) begin
          px_clr    = 1'b1;
          state_nxt = ST_STRT;
        end
      end
      ST_STRT: begin
        if (abort) begin
          state_nxt = ST_DONE;
        end else if (!bus.conv_bsy) begin
          strt_c    = 1'b1;
          tap_inc   = 1'b1;
          state_nxt = ST_FEED;
        end
      end
      ST_FEED: begin
        if (abort) begin
          state_nxt = ST_DONE;
        end else begin
          tap_inc = 1'b1;
          if (last_tap) begin
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_nxt = ST_DONE;
        end else begin
          px_inc    = 1'b1;
          state_nxt = last_px ? ST_WAIT_ACK : ST_STRT;
        end
      end
      ST_WAIT_ACK: begin
        if (abort || frm_ack) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        clr       = 1'b1;
        tx_done_c = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pixel counter: cleared on frame accept, bumped once per completed pixel
  // in GAP, and otherwise held so the final count stays visible after DONE.
  always_ff @(posedge clk) begin
    if (!rst_n || px_clr) begin
      px_cnt <= '0;
    end else if (px_inc) begin
      px_cnt <= px_cnt + PX_W'(1);
    end
  end

  // The tap bit returned from the buffer is forwarded only while feeding.
  assign bus.conv_din     = (state == ST_FEED) ? bus.img_bit : 1'b0;
  assign bus.conv_strt    = strt_c;
  assign bus.conv_tx_done = tx_done_c;
  assign frm_done         = tx_done_c;
  assign frm_busy         = (state != ST_IDLE) && (state != ST_DONE);

endmodule

// File: tb/tb_conv0_seq.sv
// -----------------------------------------------------------------------------
// tb_conv0_seq
// Scoreboard bench for conv0_seq. The stimulus thread pushes the expected
// start cycle and tap addresses of every pixel, and the expected frame-close
// pulses, into queues; a monitor on the falling edge pops and compares them
// whenever the DUT raises conv_strt or conv_tx_done, and tracks the nine
// FEED cycles that follow each start.
// -----------------------------------------------------------------------------
module tb_conv0_seq;
  import layer_pkg::*;

  typedef struct packed {
    logic [31:0]      exp_cycle;
    logic [8:0][9:0]  taps;
  } px_exp_t;

  typedef struct packed {
    logic [31:0] exp_cycle;
    logic [31:0] exp_px;
  } done_exp_t;

  logic       clk;
  logic       rst_n;
  logic       frm_start;
  logic       frm_ack;
  logic       abort;
  logic       frm_busy;
  logic       frm_done;
  logic [9:0] px_cnt;
  logic       rst_q = 1'b0;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  px_exp_t   px_q[$];
  done_exp_t done_q[$];

  conv0_seq_if bus();

  conv0_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frm_start (frm_start),
    .frm_ack   (frm_ack),
    .abort     (abort),
    .bus       (bus),
    .frm_busy  (frm_busy),
    .frm_done  (frm_done),
    .px_cnt    (px_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
    if (cyc > 20000) begin
      $display("[TB] FAIL watchdog: cycle %0d, limit 20000", cyc);
      $fatal(1, "[TB] watchdog expired");
    end
  end

  // Image buffer model: one-cycle read latency, fixed bit pattern per address.
  function automatic logic img_fn(input logic [9:0] a);
    return a[0] ^ a[1] ^ a[4] ^ a[7];
  endfunction

  always @(posedge clk) bus.img_bit <= img_fn(bus.img_addr);

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit ack, input bit abrt, input bit bsy);
    frm_start    = start;
    frm_ack      = ack;
    abort        = abrt;
    bus.conv_bsy = bsy;
  endtask

  task automatic waitCycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hand-computed tap lists for the corner cases; every other window uses
  // base = row*28 + col and tap = base + dr*28 + dc.
  function automatic px_exp_t make_px(input int p, input int exp_cycle);
    px_exp_t e;
    int      lit[9];
    int      base;
    base = (p / 26) * 28 + (p % 26);
    for (int k = 0; k < 9; k++) lit[k] = base + (k / 3) * 28 + (k % 3);
    case (p)
      0:   lit = '{0, 1, 2, 28, 29, 30, 56, 57, 58};
      1:   lit = '{1, 2, 3, 29, 30, 31, 57, 58, 59};
      26:  lit = '{28, 29, 30, 56, 57, 58, 84, 85, 86};
      675: lit = '{725, 726, 727, 753, 754, 755, 781, 782, 783};
      default: ;
    endcase
    e.exp_cycle = 32'(exp_cycle);
    for (int k = 0; k < 9; k++) e.taps[k] = 10'(lit[k]);
    return e;
  endfunction

  // Monitor: pops an expectation whenever the DUT starts a pixel or closes a
  // frame, then follows the nine FEED cycles of the started pixel.
  px_exp_t   cur;
  done_exp_t dcur;
  int        feed_idx = 0;

  always @(negedge clk) begin
    if (!rst_q) begin
      feed_idx = 0;
    end else if (bus.conv_tx_done) begin
      feed_idx = 0;
      if (done_q.size() == 0) begin
        checkOutput("unexpected_tx_done", int'(bus.conv_tx_done), 0);
      end else begin
        dcur = done_q.pop_front();
        checkOutput("done_cycle", cyc, int'(dcur.exp_cycle));
        checkOutput("done_frm_done", int'(frm_done), 1);
        checkOutput("done_frm_busy", int'(frm_busy), 0);
        checkOutput("done_px_cnt", int'(px_cnt), int'(dcur.exp_px));
      end
    end else if (feed_idx != 0) begin
      if (feed_idx <= 8) checkOutput("tap_addr", int'(bus.img_addr), int'(cur.taps[feed_idx]));
      checkOutput("tap_din", int'(bus.conv_din), int'(img_fn(cur.taps[feed_idx-1])));
      checkOutput("strt_in_feed", int'(bus.conv_strt), 0);
      feed_idx = (feed_idx == 9) ? 0 : feed_idx + 1;
    end else if (bus.conv_strt) begin
      if (px_q.size() == 0) begin
        checkOutput("unexpected_strt", int'(bus.conv_strt), 0);
      end else begin
        cur = px_q.pop_front();
        checkOutput("strt_cycle", cyc, int'(cur.exp_cycle));
        checkOutput("tap0_addr", int'(bus.img_addr), int'(cur.taps[0]));
        feed_idx = 1;
      end
    end
  end

  int c0, c2, c3, s, g, last, a, ab, r;

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_img_addr", int'(bus.img_addr), 0);
    checkOutput("rst_conv_strt", int'(bus.conv_strt), 0);
    checkOutput("rst_conv_din", int'(bus.conv_din), 0);
    checkOutput("rst_tx_done", int'(bus.conv_tx_done), 0);
    checkOutput("rst_frm_busy", int'(frm_busy), 0);
    checkOutput("rst_frm_done", int'(frm_done), 0);
    checkOutput("rst_px_cnt", int'(px_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycle(cyc + 2);

    // abort and frm_ack while idle must do nothing
    applyStimulus(0, 1, 1, 0);
    waitCycle(cyc + 1);
    applyStimulus(0, 0, 0, 0);
    waitCycle(cyc + 2);

    // Frame 1: full frame with a 5-cycle back-pressure stall on pixel 2
    c0 = cyc;
    applyStimulus(1, 0, 0, 0);
    for (int p = 0; p < 676; p++) px_q.push_back(make_px(p, c0 + 1 + 11 * p + ((p >= 2) ? 5 : 0)));
    waitCycle(c0 + 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("accept_frm_busy", int'(frm_busy), 1);
    checkOutput("accept_px_cnt", int'(px_cnt), 0);

    s = c0 + 1 + 22;
    waitCycle(s);
    applyStimulus(0, 0, 0, 1);
    waitCycle(s + 5);
    applyStimulus(0, 0, 0, 0);

    // stray frm_start / frm_ack mid-frame are ignored
    g = c0 + 1 + 11 * 5 + 5 + 2;
    waitCycle(g);
    applyStimulus(1, 1, 0, 0);
    waitCycle(g + 1);
    applyStimulus(0, 0, 0, 0);

    last = c0 + 1 + 11 * 675 + 5;
    waitCycle(last + 14);
    @(negedge clk);
    checkOutput("wait_ack_px_cnt", int'(px_cnt), 676);
    checkOutput("wait_ack_frm_busy", int'(frm_busy), 1);
    checkOutput("wait_ack_tx_done", int'(bus.conv_tx_done), 0);

    a = last + 15;
    waitCycle(a);
    applyStimulus(0, 1, 0, 0);
    done_q.push_back('{exp_cycle: 32'(a + 1), exp_px: 32'd676});
    waitCycle(a + 1);
    applyStimulus(1, 0, 0, 0);
    waitCycle(a + 2);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("post_done_frm_busy", int'(frm_busy), 0);
    checkOutput("post_done_px_cnt", int'(px_cnt), 676);
    checkOutput("post_done_strt", int'(bus.conv_strt), 0);
    waitCycle(cyc + 3);

    // Frame 2: abort during pixel 100
    c2 = cyc;
    applyStimulus(1, 0, 0, 0);
    for (int p = 0; p <= 100; p++) px_q.push_back(make_px(p, c2 + 1 + 11 * p));
    waitCycle(c2 + 1);
    applyStimulus(0, 0, 0, 0);
    ab = c2 + 1 + 1100 + 3;
    waitCycle(ab);
    applyStimulus(0, 0, 1, 0);
    done_q.push_back('{exp_cycle: 32'(ab + 1), exp_px: 32'd100});
    waitCycle(ab + 1);
    applyStimulus(0, 0, 0, 0);
    waitCycle(ab + 2);
    @(negedge clk);
    checkOutput("abort_idle_busy", int'(frm_busy), 0);
    checkOutput("abort_idle_addr", int'(bus.img_addr), 0);
    checkOutput("abort_px_cnt_hold", int'(px_cnt), 100);
    waitCycle(cyc + 2);

    // Frame 3: restart after abort, then synchronous reset mid-FEED
    c3 = cyc;
    applyStimulus(1, 0, 0, 0);
    px_q.push_back(make_px(0, c3 + 1));
    px_q.push_back(make_px(1, c3 + 12));
    waitCycle(c3 + 1);
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);
    checkOutput("restart_px_cnt", int'(px_cnt), 0);
    checkOutput("restart_addr", int'(bus.img_addr), 0);

    r = c3 + 1 + 11 + 4;
    waitCycle(r);
    rst_n = 1'b0;
    waitCycle(r + 1);
    @(negedge clk);
    checkOutput("midrst_img_addr", int'(bus.img_addr), 0);
    checkOutput("midrst_conv_strt", int'(bus.conv_strt), 0);
    checkOutput("midrst_conv_din", int'(bus.conv_din), 0);
    checkOutput("midrst_tx_done", int'(bus.conv_tx_done), 0);
    checkOutput("midrst_frm_busy", int'(frm_busy), 0);
    checkOutput("midrst_frm_done", int'(frm_done), 0);
    checkOutput("midrst_px_cnt", int'(px_cnt), 0);
    waitCycle(r + 2);
    rst_n = 1'b1;
    waitCycle(r + 6);

    checkOutput("px_queue_drained", px_q.size(), 0);
    checkOutput("done_queue_drained", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
